count_load_ctrl: RTL and testbench

COUNT_LOAD_CTRL -- requirements
Module: count_load_ctrl

---
 rtl/count_load_ctrl.sv | 121 ++++++++++++
 tb/tb_count_load_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/count_load_ctrl.sv
// Load controller for a downstream 4-bit counter: loads a start value, watches the
// counter for a terminal value and either reloads it periodically or stops after one pass.
module count_load_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [3:0] cfg_start,
    input  logic [3:0] cfg_end,
    input  logic       cfg_oneshot,
    input  logic       abort,
    input  logic [3:0] cnt_in,
    output logic       ld,
    output logic [3:0] ldvalue,
    output logic       tick,
    output logic       done,
    output logic       busy,
    output logic [7:0] reload_cnt,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] start_q, end_q;
    logic       oneshot_q;
    logic [7:0] reload_cnt_q, reload_cnt_d;
    logic       tick_q, tick_d;
    logic       cfg_take;
    logic       match;

    // Configuration handshake: a transfer happens on a rising edge where
    // cfg_valid && cfg_ready; cfg_ready is high only in IDLE, and the offered
    // fields are captured on that edge only.
    assign match = (cnt_in == end_q);

    always_comb begin
        state_d      = state_q;
        reload_cnt_d = reload_cnt_q;
        tick_d       = 1'b0;
        cfg_take     = 1'b0;
        cfg_ready    = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        ld           = 1'b0;
        ldvalue      = 4'd0;
        case (state_q)
            IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    cfg_take     = 1'b1;
                    reload_cnt_d = 8'd0;
                    state_d      = LOAD;
                end
            end
            LOAD: begin
                busy = 1'b1;
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    ld      = 1'b1;
                    ldvalue = start_q;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                // Abort outranks a terminal match: no reload, no tick, no count.
                if (abort) begin
                    state_d = IDLE;
                end else if (match) begin
                    tick_d = 1'b1;
                    if (oneshot_q) begin
                        state_d = DONE;
                    end else begin
                        ld      = 1'b1;
                        ldvalue = start_q;
                        if (reload_cnt_q != 8'hFF) begin
                            reload_cnt_d = reload_cnt_q + 8'd1;
                        end
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            start_q      <= 4'd0;
            end_q        <= 4'd0;
            oneshot_q    <= 1'b0;
            reload_cnt_q <= 8'd0;
            tick_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            reload_cnt_q <= reload_cnt_d;
            tick_q       <= tick_d;
            if (cfg_take) begin
                start_q   <= cfg_start;
                end_q     <= cfg_end;
                oneshot_q <= cfg_oneshot;
            end
        end
    end

    assign tick       = tick_q;
    assign reload_cnt = reload_cnt_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_count_load_ctrl.sv
// Bench for count_load_ctrl driving a real 4-bit loadable counter; expectations come
// from closed-form period arithmetic on each accepted configuration.
module tb_count_load_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [3:0] cfg_start;
    logic [3:0] cfg_end;
    logic       cfg_oneshot;
    logic       abort;
    logic [3:0] cnt_q;
    logic       ld;
    logic [3:0] ldvalue;
    logic       tick;
    logic       done;
    logic       busy;
    logic [7:0] reload_cnt;
    logic [1:0] dbg_state;

    int checks   = 0;
    int failures = 0;

    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    // Downstream counter: load on ld, otherwise increment with 4-bit wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)     cnt_q <= 4'd0;
        else if (ld) cnt_q <= ldvalue;
        else         cnt_q <= cnt_q + 4'd1;
    end

    count_load_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_start  (cfg_start),
        .cfg_end    (cfg_end),
        .cfg_oneshot(cfg_oneshot),
        .abort      (abort),
        .cnt_in     (cnt_q),
        .ld         (ld),
        .ldvalue    (ldvalue),
        .tick       (tick),
        .done       (done),
        .busy       (busy),
        .reload_cnt (reload_cnt),
        .dbg_state  (dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int period(input int s, input int e);
        return ((e - s + 16) % 16) + 1;
    endfunction

    // Random traffic on the cfg port; it must be ignored outside IDLE.
    task automatic noise();
        cfg_valid   = 1'($urandom_range(0, 1));
        cfg_start   = 4'($urandom_range(0, 15));
        cfg_end     = 4'($urandom_range(0, 15));
        cfg_oneshot = 1'($urandom_range(0, 1));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ld"}, 32'(ld), 0);
        check({tag, "_ldvalue"}, 32'(ldvalue), 0);
        check({tag, "_tick"}, 32'(tick), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_cfg_ready"}, 32'(cfg_ready), 1);
        check({tag, "_reload_cnt"}, 32'(reload_cnt), 0);
    endtask

    // Entered just after the handshake edge; leaves just after the edge into RUN.
    task automatic check_load(input int s);
        noise();
        abort = 1'b0;
        @(negedge clk);
        check("load_ld", 32'(ld), 1);
        check("load_ldvalue", 32'(ldvalue), 32'(s));
        check("load_busy", 32'(busy), 1);
        check("load_cfg_ready", 32'(cfg_ready), 0);
        check("load_reload_cnt", 32'(reload_cnt), 0);
        @(posedge clk); #1;
    endtask

    task automatic offer(input int s, input int e, input bit os);
        cfg_valid   = 1'b1;
        cfg_start   = 4'(s);
        cfg_end     = 4'(e);
        cfg_oneshot = os;
        abort       = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("idle_cfg_ready", 32'(cfg_ready), 1);
        check("idle_busy", 32'(busy), 0);
        check("idle_ld", 32'(ld), 0);
        @(posedge clk); #1;
        check_load(s);
    endtask

    task automatic run_periodic(input int s, input int e, input int n, input bit do_abort);
        int p;
        int last;
        bit ab;
        bit exp_ld;
        int exp_rc;
        p = period(s, e);
        exp_q.delete();
        for (int k = 0; k < n; k++) exp_q.push_back(4'((s + (k % p)) % 16));
        for (int k = 0; k < n; k++) begin
            noise();
            ab    = do_abort && (k == n - 1);
            abort = ab;
            @(negedge clk);
            last   = int'(exp_q.pop_front());
            exp_ld = ((k % p) == p - 1) && !ab;
            exp_rc = (k / p > 255) ? 255 : k / p;
            check("run_cnt", 32'(cnt_q), 32'(last));
            check("run_ld", 32'(ld), 32'(exp_ld));
            check("run_ldvalue", 32'(ldvalue), exp_ld ? 32'(s) : 32'd0);
            check("run_tick", 32'(tick), 32'((k >= 1) && (((k - 1) % p) == p - 1)));
            check("run_reload_cnt", 32'(reload_cnt), 32'(exp_rc));
            check("run_busy", 32'(busy), 1);
            check("run_cfg_ready", 32'(cfg_ready), 0);
            check("run_done", 32'(done), 0);
            @(posedge clk); #1;
        end
        if (do_abort) begin
            cfg_valid = 1'b0;
            abort     = 1'b0;
            exp_rc    = ((n - 1) / p > 255) ? 255 : (n - 1) / p;
            @(negedge clk);
            check("abort_tick", 32'(tick), 0);
            check("abort_busy", 32'(busy), 0);
            check("abort_cfg_ready", 32'(cfg_ready), 1);
            check("abort_reload_cnt", 32'(reload_cnt), 32'(exp_rc));
            check("abort_cnt", 32'(cnt_q), 32'((last + 1) % 16));
            @(posedge clk); #1;
        end
    endtask

    task automatic run_oneshot(input int s, input int e);
        int p;
        p = period(s, e);
        for (int k = 0; k < p; k++) begin
            noise();
            abort = 1'b0;
            @(negedge clk);
            check("os_cnt", 32'(cnt_q), 32'((s + k) % 16));
            check("os_ld", 32'(ld), 0);
            check("os_tick", 32'(tick), 0);
            check("os_done", 32'(done), 0);
            check("os_busy", 32'(busy), 1);
            check("os_reload_cnt", 32'(reload_cnt), 0);
            @(posedge clk); #1;
        end
        noise();
        abort = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("done_done", 32'(done), 1);
        check("done_tick", 32'(tick), 1);
        check("done_busy", 32'(busy), 0);
        check("done_cfg_ready", 32'(cfg_ready), 0);
        check("done_ld", 32'(ld), 0);
        check("done_cnt", 32'(cnt_q), 32'((e + 1) % 16));
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        abort     = 1'b0;
        @(negedge clk);
        check("post_done", 32'(done), 0);
        check("post_tick", 32'(tick), 0);
        check("post_cfg_ready", 32'(cfg_ready), 1);
        check("post_cnt", 32'(cnt_q), 32'((e + 2) % 16));
        @(posedge clk); #1;
    endtask

    initial begin
        int s;
        int e;
        bit os;
        rst         = 1'b1;
        cfg_valid   = 1'b0;
        cfg_start   = 4'd0;
        cfg_end     = 4'd0;
        cfg_oneshot = 1'b0;
        abort       = 1'b0;
        #12;
        check_reset_values("reset");

        // Offer before reset release so the first edge afterwards takes it.
        cfg_valid = 1'b1;
        cfg_start = 4'd3;
        cfg_end   = 4'd6;
        #1 rst = 1'b0;
        #1 check("first_cfg_ready", 32'(cfg_ready), 1);
        @(posedge clk); #1;
        check_load(3);
        run_periodic(3, 6, 12, 1'b1);

        offer(14, 1, 1'b0);
        run_periodic(14, 1, 10, 1'b1);

        offer(5, 5, 1'b0);
        run_periodic(5, 5, 300, 1'b1);

        offer(0, 2, 1'b1);
        run_oneshot(0, 2);

        offer(3, 6, 1'b0);
        run_periodic(3, 6, 4, 1'b0);
        #2 rst = 1'b1;
        #1 check_reset_values("async_rst");
        check("async_rst_cnt", 32'(cnt_q), 0);
        @(posedge clk); #3;
        rst       = 1'b0;
        cfg_valid = 1'b0;
        @(posedge clk); #1;
        offer(9, 12, 1'b0);
        run_periodic(9, 12, 9, 1'b1);

        for (int i = 0; i < 25; i++) begin
            s  = int'($urandom_range(0, 15));
            e  = int'($urandom_range(0, 15));
            os = 1'($urandom_range(0, 1));
            offer(s, e, os);
            if (os) run_oneshot(s, e);
            else    run_periodic(s, e, int'($urandom_range(1, 40)), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
